bridge_dataslot_locator: RTL and testbench
==========================================

Name: bridge_dataslot_locator

Overview:
- Sequencer that walks the bridge dataslot table in BRAM to find the entry whose slot ID matches a requested ID.
- Issues reads on the bridge dataslot bus, then latches the entry's byte base address, its size word and a found flag.
- These outputs configure the downstream size-override stage: slot_base_address, slot_base_found and the table size word.
- Runs only on request. While idle it is the sole master of its bus port; it issues no other traffic.

Parameters:
- TABLE_BASE, 32'hF800_2000, byte address of table entry 0.
- MAX_SLOTS, 32, number of entries scanned. Must be ≥1 and a power of two ≤ 256.
- TIMEOUT, 255, maximum cycles to wait for rd_data_valid after a read is issued.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; ignored while busy.
- slot_id  in  16  ID to locate; sampled on the accepted start.
- bus_addr  out  32  byte address of the current read.
- bus_rd  out  1  read strobe, one cycle per read.
- bus_rd_data  in  32  read data.
- bus_rd_data_valid  in  1  read data qualifier.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan ends for any reason.
- slot_base_found  out  1  last scan matched.
- slot_base_address  out  32  byte address of the matching entry (word 0).
- slot_size  out  32  word 1 of the matching entry (size_lower).
- timeout_err  out  1  last scan aborted on read timeout.

Behaviour:
- Entry layout: entry k at TABLE_BASE + 8·k. Word 0 holds {params[31:16], id[15:0]}; word 1 at +4 is the size.
- Reset: all outputs 0. State IDLE, index 0, timer 0.
- State IDLE:
  - On start, latch slot_id, clear index, set busy = 1, go to RD_ID.
  - On entering a new scan, clear slot_base_found and timeout_err on the same edge. slot_base_address and slot_size hold their old values until overwritten.
- State RD_ID:
  - Drive bus_addr = TABLE_BASE + {index, 3'b000}, pulse bus_rd for 1 cycle, go to WAIT_ID.
- State WAIT_ID:
  - Hold bus_addr. bus_rd = 0.
  - On valid: if rd_data[15:0] == latched ID, go to RD_SIZE.
  - Otherwise, if index == MAX_SLOTS−1, go to FINISH with found = 0.
  - Otherwise increment index and go to RD_ID.
- State RD_SIZE:
  - bus_addr = entry base + 4, pulse bus_rd, go to WAIT_SIZE.
- State WAIT_SIZE:
  - On valid: latch slot_size = rd_data and slot_base_address = entry base, set found = 1, go to FINISH.
- State FINISH:
  - Pulse done for 1 cycle, busy = 0, return to IDLE.
  - slot_base_found is registered and stays stable until the next accepted start.
- Timeout:
  - Per-read cycle counter, cleared on each bus_rd and counting in WAIT_*.
  - If it reaches TIMEOUT with no valid: set timeout_err = 1, found = 0, go to FINISH.
  - A late valid arriving in IDLE is ignored.
- Latency:
  - With bus read latency L (valid L cycles after bus_rd), each read costs L+1 cycles.
  - Match at index k: done fires (k+2)(L+1)+1 cycles after the start cycle.
- Boundary rules:
  - start while busy is dropped, no queueing.
  - start in the same cycle as done is dropped; the requester retries.
  - Valid in the same cycle as the timeout threshold: the valid wins.
  - Only the first matching entry is reported.
  - Index width is clog2(MAX_SLOTS). There is no wrap; the last index terminates the scan.
  - Reset mid-scan returns to IDLE immediately, clears all outputs and issues no further bus_rd.
  - bus_addr is 0 in IDLE.

Decomposition:
- bridge_pkg gains:
  - DATASLOT_ENTRY_BYTES = 8, DATASLOT_SIZE_OFFSET = 4.
  - A dataslot_even_t struct {params, id} mirroring the existing odd-word type.
  - A locator_state_t enum (IDLE, RD_ID, WAIT_ID, RD_SIZE, WAIT_SIZE, FINISH).
- One sub-module, bridge_read_timer: a loadable down-counter with an expired flag, reusable by other bridge masters.
- The FSM and datapath remain in this module.

Test Plan:
- Table ID[0] = 16'h0003, size 32'h0001_0000. Start with slot_id = 3, L = 1 → exactly 2 reads; found = 1, base = F800_2000, size = 0001_0000, done at cycle 5.
- Match at entry 5 (ID 16'h0010, size 32'h200), L = 2 → 7 reads; base = F800_2028, size = 32'h200, done at cycle 22.
- No entry matches ID 16'h00FF → 32 reads, addresses F800_2000..F800_20F8 in steps of 8; found = 0, timeout_err = 0, done pulsed once.
- Memory never returns valid, TIMEOUT = 15 → one bus_rd, done 16 cycles later; timeout_err = 1, found = 0; a late valid is ignored.
- Second start pulsed during an active scan, and again on the done cycle → both dropped; exactly one done, bus_rd count unchanged.
- reset_n asserted in WAIT_ID at entry 3 → all outputs 0 asynchronously; after release, no bus_rd until a new start, and a new scan runs correctly from entry 0.

Source files
------------

// File: rtl/bridge_dataslot_locator_pkg.sv
// Shared types for the bridge dataslot locator.
// Entry geometry, dataslot word views and FSM state encoding.
package bridge_dataslot_locator_pkg;

  localparam int unsigned DATASLOT_ENTRY_BYTES = 8;
  localparam int unsigned DATASLOT_SIZE_OFFSET = 4;

  typedef struct packed {
    logic [31:0] size_lower;
  } dataslot_odd_t;

  typedef struct packed {
    logic [15:0] params;
    logic [15:0] id;
  } dataslot_even_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_SIZE,
    WAIT_SIZE,
    FINISH
  } locator_state_t;

endpackage

// File: rtl/bridge_dataslot_locator_if.sv
// Bridge dataslot read bus: bus_addr/bus_rd from the master,
// bus_rd_data/bus_rd_data_valid back from the memory side.
interface bridge_dataslot_locator_if;

  logic [31:0] bus_addr;
  logic        bus_rd;
  logic [31:0] bus_rd_data;
  logic        bus_rd_data_valid;

  modport master (
    output bus_addr,
    output bus_rd,
    input  bus_rd_data,
    input  bus_rd_data_valid
  );

  modport slave (
    input  bus_addr,
    input  bus_rd,
    output bus_rd_data,
    output bus_rd_data_valid
  );

endinterface

// File: rtl/bridge_dataslot_locator_read_timer.sv
// bridge_read_timer: loadable down-counter, expired when zero.
// Ports: clk, reset_n, load, load_value, enable, expired.
module bridge_read_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/bridge_dataslot_locator.sv
// Scans the dataslot table for slot_id; reports base, size, found.
// Ports: clk, reset_n, start, slot_id, bus (master), status outputs.
module bridge_dataslot_locator
  import bridge_dataslot_locator_pkg::*;
#(
  parameter logic [31:0] TABLE_BASE = 32'hF800_2000,
  parameter int unsigned MAX_SLOTS  = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [15:0]                slot_id,
  bridge_dataslot_locator_if.master  bus,
  output logic                       busy,
  output logic                       done,
  output logic                       slot_base_found,
  output logic [31:0]                slot_base_address,
  output logic [31:0]                slot_size,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W =
    (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SLOTS - 1);
  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th wait cycle.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  locator_state_t   state, state_d;
  logic [IDX_W-1:0] index, index_d;
  logic [15:0]      id_q, id_d;
  logic             found_q, found_d;
  logic             terr_q, terr_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      size_q, size_d;

  dataslot_even_t   rd_word;
  logic [31:0]      entry_base;
  logic             waiting;
  logic             expired;

  assign rd_word    = bus.bus_rd_data;
  assign entry_base = TABLE_BASE
                    + 32'(index) * 32'(DATASLOT_ENTRY_BYTES);
  assign waiting    = (state == WAIT_ID) || (state == WAIT_SIZE);

  bridge_read_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (bus.bus_rd),
    .load_value (TMR_LOAD),
    .enable     (waiting),
    .expired    (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      index   <= '0;
      id_q    <= '0;
      found_q <= 1'b0;
      terr_q  <= 1'b0;
      base_q  <= '0;
      size_q  <= '0;
    end else begin
      state   <= state_d;
      index   <= index_d;
      id_q    <= id_d;
      found_q <= found_d;
      terr_q  <= terr_d;
      base_q  <= base_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d      = state;
    index_d      = index;
    id_d         = id_q;
    found_d      = found_q;
    terr_d       = terr_q;
    base_d       = base_q;
    size_d       = size_q;
    bus.bus_addr = '0;
    bus.bus_rd   = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          id_d    = slot_id;
          index_d = '0;
          found_d = 1'b0;
          terr_d  = 1'b0;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        bus.bus_addr = entry_base;
        bus.bus_rd   = 1'b1;
        state_d      = WAIT_ID;
      end
      WAIT_ID: begin
        bus.bus_addr = entry_base;
        // A valid on the expiry cycle still counts.
        if (bus.bus_rd_data_valid) begin
          if (rd_word.id == id_q) begin
            state_d = RD_SIZE;
          end else if (index == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            index_d = index + 1'b1;
            state_d = RD_ID;
          end
        end else if (expired) begin
          terr_d  = 1'b1;
          found_d = 1'b0;
          state_d = FINISH;
        end
      end
      RD_SIZE: begin
        bus.bus_addr = entry_base + 32'(DATASLOT_SIZE_OFFSET);
        bus.bus_rd   = 1'b1;
        state_d      = WAIT_SIZE;
      end
      WAIT_SIZE: begin
        bus.bus_addr = entry_base + 32'(DATASLOT_SIZE_OFFSET);
        if (bus.bus_rd_data_valid) begin
          size_d  = rd_word;
          base_d  = entry_base;
          found_d = 1'b1;
          state_d = FINISH;
        end else if (expired) begin
          terr_d  = 1'b1;
          found_d = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy              = waiting
                          || (state == RD_ID)
                          || (state == RD_SIZE);
  assign slot_base_found   = found_q;
  assign timeout_err       = terr_q;
  assign slot_base_address = base_q;
  assign slot_size         = size_q;

endmodule

// File: tb/tb_bridge_dataslot_locator.sv
// Scoreboard bench for bridge_dataslot_locator with a
// latency-programmable memory responder and table model.
module tb_bridge_dataslot_locator;

  localparam logic [31:0] TB_BASE = 32'hF800_2000;
  localparam int NS  = 32;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] slot_id = '0;
  logic        busy, done, found, terr;
  logic [31:0] base, size;

  bridge_dataslot_locator_if bus ();

  bridge_dataslot_locator #(
    .TABLE_BASE (TB_BASE),
    .MAX_SLOTS  (NS),
    .TIMEOUT    (TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .slot_id           (slot_id),
    .bus               (bus),
    .busy              (busy),
    .done              (done),
    .slot_base_found   (found),
    .slot_base_address (base),
    .slot_size         (size),
    .timeout_err       (terr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] t_id   [NS];
  logic [15:0] t_par  [NS];
  logic [31:0] t_size [NS];

  int          lat = 1;
  bit          resp_en = 1'b1;
  bit          inj = 1'b0;
  logic [31:0] inj_data = '0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          found;
    logic [31:0] base;
    logic [31:0] size;
    bit          terr;
    int          done_cyc;
  } exp_t;

  rsp_t        rq [$];
  exp_t        sb [$];
  logic [31:0] aq [$];
  logic [31:0] m_base = '0;
  logic [31:0] m_size = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic logic [31:0] mem_read(logic [31:0] a);
    logic [31:0] off;
    int k;
    off = a - TB_BASE;
    k = int'(off >> 3);
    if (a < TB_BASE || k >= NS) return $urandom;
    return off[2] ? t_size[k] : {t_par[k], t_id[k]};
  endfunction

  // Memory responder: valid arrives lat cycles after bus_rd.
  initial begin
    bus.bus_rd_data_valid = 1'b0;
    bus.bus_rd_data = '0;
    forever begin
      @(negedge clk);
      bus.bus_rd_data_valid = 1'b0;
      bus.bus_rd_data = $urandom;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        bus.bus_rd_data_valid = 1'b1;
        bus.bus_rd_data = rq[0].data;
        void'(rq.pop_front());
      end else if (inj) begin
        bus.bus_rd_data_valid = 1'b1;
        bus.bus_rd_data = inj_data;
      end
      if (bus.bus_rd && resp_en)
        rq.push_back('{cyc + lat, mem_read(bus.bus_addr)});
    end
  end

  // Monitor: pops expected reads and results as the DUT shows them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (bus.bus_rd) begin
        if (aq.size() == 0) flag("extra_rd");
        else chk("rd_addr", bus.bus_addr, aq.pop_front());
      end
      if (!busy && !done) chk("idle_addr", bus.bus_addr, 32'h0);
      if (done) begin
        if (sb.size() == 0) begin
          flag("extra_done");
        end else begin
          e = sb.pop_front();
          chk("found", {31'h0, found}, {31'h0, e.found});
          chk("base", base, e.base);
          chk("size", size, e.size);
          chk("terr", {31'h0, terr}, {31'h0, e.terr});
          chk("done_cyc", cyc, e.done_cyc);
          chk("busy_at_done", {31'h0, busy}, 32'h0);
          chk("pending_rd", aq.size(), 32'h0);
        end
      end
    end
  end

  // Reference: first matching entry decides the whole scan.
  task automatic scan(logic [15:0] id);
    exp_t e;
    int k;
    int s;
    k = -1;
    for (int i = 0; i < NS; i++)
      if (k < 0 && t_id[i] == id) k = i;
    s = cyc;
    e.terr = 1'b0;
    if (!resp_en) begin
      aq.push_back(TB_BASE);
      e.terr = 1'b1;
      e.found = 1'b0;
      e.done_cyc = s + TMO + 2;
    end else if (k >= 0) begin
      for (int i = 0; i <= k; i++) aq.push_back(TB_BASE + 8 * i);
      aq.push_back(TB_BASE + 8 * k + 4);
      e.found = 1'b1;
      m_base = TB_BASE + 8 * k;
      m_size = t_size[k];
      e.done_cyc = s + (k + 2) * (lat + 1) + 1;
    end else begin
      for (int i = 0; i < NS; i++) aq.push_back(TB_BASE + 8 * i);
      e.found = 1'b0;
      e.done_cyc = s + NS * (lat + 1) + 1;
    end
    e.base = m_base;
    e.size = m_size;
    sb.push_back(e);
    start = 1'b1;
    slot_id = id;
    @(negedge clk);
    start = 1'b0;
    slot_id = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("scan_bound", sb.size(), 32'h0);
    sb.delete();
    aq.delete();
    @(negedge clk);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_done"}, {31'h0, done}, 32'h0);
    chk({nm, "_found"}, {31'h0, found}, 32'h0);
    chk({nm, "_terr"}, {31'h0, terr}, 32'h0);
    chk({nm, "_base"}, base, 32'h0);
    chk({nm, "_size"}, size, 32'h0);
    chk({nm, "_rd"}, {31'h0, bus.bus_rd}, 32'h0);
    chk({nm, "_addr"}, bus.bus_addr, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int s;
    int n;
    for (int i = 0; i < NS; i++) begin
      t_id[i] = 16'h1000 + 16'(i);
      t_par[i] = 16'($urandom);
      t_size[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    t_id[0] = 16'h0003;
    t_size[0] = 32'h0001_0000;
    lat = 1;
    scan(16'h0003);
    wait_idle();

    t_id[5] = 16'h0010;
    t_size[5] = 32'h0000_0200;
    lat = 2;
    scan(16'h0010);
    wait_idle();

    lat = 1;
    scan(16'h00FF);
    wait_idle();

    resp_en = 1'b0;
    scan(16'h0003);
    wait_idle();
    resp_en = 1'b1;
    inj_data = {16'h0, 16'h0003};
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_terr", {31'h0, terr}, 32'h1);
    chk("late_found", {31'h0, found}, 32'h0);
    chk("late_busy", {31'h0, busy}, 32'h0);

    lat = 1;
    scan(16'h0010);
    d = sb[0].done_cyc;
    repeat (3) @(negedge clk);
    start = 1'b1;
    slot_id = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (cyc < d && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    slot_id = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("drop_busy", {31'h0, busy}, 32'h0);
    wait_idle();

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NS; i++) begin
        t_id[i] = 16'($urandom_range(0, 31));
        t_par[i] = 16'($urandom);
        t_size[i] = $urandom;
      end
      lat = $urandom_range(1, 3);
      resp_en = (r % 5 != 4);
      scan(16'($urandom_range(0, 40)));
      wait_idle();
    end
    resp_en = 1'b1;

    for (int i = 0; i < NS; i++) t_id[i] = 16'h2000 + 16'(i);
    t_id[0] = 16'h0003;
    t_size[0] = 32'h0001_0000;
    lat = 2;
    scan(16'h00FF);
    s = cyc - 1;
    n = 0;
    while (cyc < s + 11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    rq.delete();
    sb.delete();
    aq.delete();
    m_base = '0;
    m_size = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    lat = 1;
    scan(16'h0003);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
